// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID pipeline register layout used by the fetch stage.
package cpu_pkg;
   localparam int          XLEN             = 32;
   localparam logic [6:0]  OPC_JAL          = 7'b1101111;
   localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            valid;
      logic            pred;
   } ifid_t;
endpackage

// File: rtl/if_predecode.sv
// Static fetch predictor: JAL always taken, backward conditional branches taken.
// Used only when IF_STATIC_PREDICT_EN is defined; JALR is never predicted.
module if_predecode
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   output logic            taken_o,
   output logic [XLEN-1:0] target_o
);
   logic [XLEN-1:0] j_imm, b_imm;
   logic            is_jal, is_br;

   assign j_imm  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
   assign b_imm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign is_jal = (instr_i[6:0] == OPC_JAL);
   assign is_br  = (instr_i[6:0] == OPC_BRANCH);

   // imm sign bit sits in instr[31] for B-type, so it alone marks a backward branch
   assign taken_o  = is_jal | (is_br & instr_i[31]);
   assign target_o = pc_i + (is_jal ? j_imm : b_imm);
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// Define IF_STATIC_PREDICT_EN to enable static JAL/backward-branch prediction.
module if_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              ROM_AW   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_dout,
   output logic [XLEN-1:0]   ifid_pc,
   output logic [31:0]       ifid_instr,
   output logic              ifid_valid,
   output logic              ifid_pred_taken
);
   logic [XLEN-1:0] pc_q, pc_d, fetch_next;
   ifid_t           ifid_q, ifid_d;
   logic            pred_taken;

`ifdef IF_STATIC_PREDICT_EN
   logic [XLEN-1:0] pred_target;

   if_predecode u_predecode (
      .pc_i     (pc_q),
      .instr_i  (rom_dout),
      .taken_o  (pred_taken),
      .target_o (pred_target)
   );
   assign fetch_next = pred_taken ? pred_target : pc_q + 32'd4;
`else
   assign pred_taken = 1'b0;
   assign fetch_next = pc_q + 32'd4;
`endif

   assign rom_addr = pc_q[ROM_AW+1:2];

   always_comb begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      if (flush) begin
         ifid_d.valid = 1'b0;
         ifid_d.instr = NOP_INSTR;
         ifid_d.pred  = 1'b0;
      end else if (!stall) begin
         ifid_d = '{pc: pc_q, instr: rom_dout, valid: 1'b1, pred: pred_taken};
      end
      // a redirect wins over stall so a resolved branch is never lost to a hazard hold
      if (redirect_valid)
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      else if (!stall)
         pc_d = fetch_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         ifid_q <= '0;
      end else begin
         pc_q   <= pc_d;
         ifid_q <= ifid_d;
      end
   end

   assign ifid_pc         = ifid_q.pc;
   assign ifid_instr      = ifid_q.instr;
   assign ifid_valid      = ifid_q.valid;
   assign ifid_pred_taken = ifid_q.pred;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios then random control traffic,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_if_fetch_unit;
   logic        clk;
   logic        rst, stall, flush, redirect_valid;
   logic [31:0] redirect_pc;
   logic [5:0]  rom_addr;
   logic [31:0] rom_dout;
   logic [31:0] ifid_pc, ifid_instr;
   logic        ifid_valid, ifid_pred_taken;

   logic [31:0] rom [64];
   assign rom_dout = rom[rom_addr];

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [31:0] m_pc, m_ifpc, m_ifinstr;
   logic        m_ifvalid, m_ifpred;

   if_fetch_unit #(.RESET_PC(32'h0), .ROM_AW(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .rom_addr        (rom_addr),
      .rom_dout        (rom_dout),
      .ifid_pc         (ifid_pc),
      .ifid_instr      (ifid_instr),
      .ifid_valid      (ifid_valid),
      .ifid_pred_taken (ifid_pred_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   // static prediction from the ISA encoding: offsets rebuilt as signed integers
   task automatic predict(input logic [31:0] pc, input logic [31:0] ins,
                          output logic taken, output logic [31:0] tgt);
      logic signed [20:0] joff;
      logic signed [12:0] boff;
      taken = 1'b0;
      tgt   = pc + 32'd4;
`ifdef IF_STATIC_PREDICT_EN
      joff = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      boff = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      if (ins[6:0] == 7'h6f) begin
         taken = 1'b1;
         tgt   = pc + 32'(int'(joff));
      end else if (ins[6:0] == 7'h63 && boff < 0) begin
         taken = 1'b1;
         tgt   = pc + 32'(int'(boff));
      end
`endif
   endtask

   task automatic cycle();
      logic [31:0] ins, tgt;
      logic        pt;
      ins = rom[m_pc[7:2]];
      predict(m_pc, ins, pt, tgt);
      @(posedge clk);
      if (rst) begin
         m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = 32'h0; m_ifvalid = 1'b0; m_ifpred = 1'b0;
      end else begin
         if (flush) begin
            m_ifvalid = 1'b0; m_ifinstr = 32'h0; m_ifpred = 1'b0;
         end else if (!stall) begin
            m_ifpc = m_pc; m_ifinstr = ins; m_ifvalid = 1'b1; m_ifpred = pt;
         end
         if (redirect_valid) m_pc = redirect_pc & ~32'h3;
         else if (!stall)    m_pc = pt ? tgt : m_pc + 32'd4;
      end
      #1;
      chk("rom_addr", 32'(rom_addr), 32'(m_pc[7:2]));
      chk("ifid_valid", 32'(ifid_valid), 32'(m_ifvalid));
      chk("ifid_instr", ifid_instr, m_ifinstr);
      chk("ifid_pred", 32'(ifid_pred_taken), 32'(m_ifpred));
      if (m_ifvalid) chk("ifid_pc", ifid_pc, m_ifpc);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = $urandom;
      rom[0]  = 32'h0000_3f37;
      rom[1]  = 32'h0000_0013;
      rom[7]  = 32'h0000_0f6f;
      rom[8]  = 32'h0000_1c63;
      rom[13] = 32'hfc00_0ae3;
      rom[63] = 32'h0000_0013;
      m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = 32'h0; m_ifvalid = 1'b0; m_ifpred = 1'b0;
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;

      // reset state
      cycle();
      chk("rst_valid", 32'(ifid_valid), 32'h0);
      chk("rst_instr", ifid_instr, 32'h0);
      chk("rst_pc", ifid_pc, 32'h0);
      redirect_valid = 1'b0; rst = 1'b0;
      #1 chk("rel_addr", 32'(rom_addr), 32'h0);

      // reset release and sequential fetch
      cycle();
      chk("rel_ifpc", ifid_pc, 32'h0);
      chk("rel_instr", ifid_instr, 32'h0000_3f37);
      chk("rel_ifvalid", 32'(ifid_valid), 32'h1);
      cycle();
      chk("seq_addr", 32'(rom_addr), 32'h2);
      stall = 1'b1;
      repeat (2) begin
         cycle();
         chk("stall_ifpc", ifid_pc, 32'h4);
         chk("stall_addr", 32'(rom_addr), 32'h2);
      end
      stall = 1'b0;

      // redirect with flush, low address bits dropped
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0021; flush = 1'b1;
      cycle();
      chk("redir_addr", 32'(rom_addr), 32'h8);
      chk("redir_bubble", 32'(ifid_valid), 32'h0);
      redirect_valid = 1'b0; flush = 1'b0;
      cycle();
      chk("redir_instr", ifid_instr, 32'h0000_1c63);
      chk("redir_ifpc", ifid_pc, 32'h20);

      // backward branch at 0x34
      redirect_valid = 1'b1; redirect_pc = 32'h34; flush = 1'b1;
      cycle();
      redirect_valid = 1'b0; flush = 1'b0;
      cycle();
`ifdef IF_STATIC_PREDICT_EN
      chk("bwd_addr", 32'(rom_addr), 32'h2);
      chk("bwd_pred", 32'(ifid_pred_taken), 32'h1);
`else
      chk("bwd_addr", 32'(rom_addr), 32'he);
      chk("bwd_pred", 32'(ifid_pred_taken), 32'h0);
`endif

      // JAL self-loop at 0x1C
      redirect_valid = 1'b1; redirect_pc = 32'h1c; flush = 1'b1;
      cycle();
      redirect_valid = 1'b0; flush = 1'b0;
      repeat (3) begin
         cycle();
`ifdef IF_STATIC_PREDICT_EN
         chk("jal_addr", 32'(rom_addr), 32'h7);
         chk("jal_pred", 32'(ifid_pred_taken), 32'h1);
`endif
      end

      // 32-bit PC wrap
      redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc; flush = 1'b1;
      cycle();
      chk("wrap_addr0", 32'(rom_addr), 32'h3f);
      redirect_valid = 1'b0; flush = 1'b0;
      cycle();
      chk("wrap_addr1", 32'(rom_addr), 32'h0);
      chk("wrap_ifpc", ifid_pc, 32'hffff_fffc);

      // reset mid-operation with a coinciding redirect and stall
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
      cycle();
      chk("midrst_addr", 32'(rom_addr), 32'h0);
      chk("midrst_valid", 32'(ifid_valid), 32'h0);
      rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0;

      // random control traffic
      for (int n = 0; n < 400; n++) begin
         rst            = ($urandom_range(99) < 2);
         stall          = ($urandom_range(99) < 20);
         flush          = ($urandom_range(99) < 10);
         redirect_valid = ($urandom_range(99) < 10);
         redirect_pc    = $urandom;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter ROM_AW, default 6: instruction ROM word-address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port stall, input, 1: hazard hold; PC and IF/ID register keep their values.
REQ-006 SHALL have port flush, input, 1: squash the IF/ID register contents.
REQ-007 SHALL have port redirect_valid, input, 1: EX-stage PC redirect (taken branch, jump, mispredict).
REQ-008 SHALL have port redirect_pc, input, 32: redirect target byte address.
REQ-009 SHALL have port rom_addr, output, ROM_AW: word address driven to the instruction ROM.
REQ-010 SHALL have port rom_dout, input, 32: combinational ROM read data for rom_addr.
REQ-011 SHALL have ports ifid_pc (output, 32), ifid_instr (output, 32) and ifid_valid (output, 1): IF/ID register contents.
REQ-012 SHALL have port ifid_pred_taken, output, 1: fetch predicted the instruction as taken.

Function
REQ-013 SHALL drive rom_addr = pc[ROM_AW+1:2] combinationally from the PC register; word index wraps modulo 2^ROM_AW.
REQ-014 SHALL, when not stalled, capture ifid_pc<=pc, ifid_instr<=rom_dout, ifid_valid<=1 each cycle; latency is 1 cycle from PC to IF/ID.
REQ-015 SHALL select next PC with priority rst > redirect_valid > stall > prediction > pc+4.
REQ-016 SHALL force redirect_pc[1:0] to 2'b00 when loading it into the PC.
REQ-017 SHALL let redirect_valid update the PC even while stall=1.
REQ-018 SHALL, on flush, load ifid_valid=0, ifid_instr=32'h0000_0000 (nop), ifid_pred_taken=0 regardless of stall; ifid_pc is don't-care.
REQ-019 SHALL, with stall=1 and flush=0, hold ifid_* and the PC (unless redirected).
REQ-020 SHALL, on redirect_valid and flush together, load PC=redirect_pc and a bubble into IF/ID in the same cycle.
REQ-021 SHALL wrap the PC in 32 bits: pc+4 from 32'hFFFF_FFFC yields 32'h0000_0000.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, load pc=RESET_PC, ifid_pc=0, ifid_instr=0, ifid_valid=0, ifid_pred_taken=0, overriding all other inputs.
REQ-023 SHALL present the instruction at RESET_PC in IF/ID on the first edge after rst deasserts.
REQ-024 SHALL discard any in-flight redirect or stall coinciding with reset.

Configuration
REQ-025 SHALL, with macro IF_STATIC_PREDICT_EN defined, predecode rom_dout: JAL (opcode 1101111) predicts taken to pc+J-imm; B-type (1100011) with imm[12]=1 (backward) predicts taken to pc+B-imm; ifid_pred_taken captures the prediction; JALR is never predicted.
REQ-026 SHALL, without IF_STATIC_PREDICT_EN, compute next PC as pc+4 only and tie ifid_pred_taken to 0.

Structure
REQ-027 SHALL take from shared package cpu_pkg: XLEN, OPC_JAL, OPC_BRANCH, NOP_INSTR, DEFAULT_RESET_PC.
REQ-028 SHALL place immediate extraction and the prediction decision in sub-module if_predecode, instantiated only under IF_STATIC_PREDICT_EN; the ROM is instantiated outside this block.

Verification
REQ-029 SHALL cover reset release: rom_addr=0; next edge ifid_pc=0, ifid_instr=32'h0000_3f37, ifid_valid=1.
REQ-030 SHALL cover sequential fetch plus stall: PC 0,4,8; stall held 2 cycles at PC 8 -> ifid_pc stays 4, rom_addr stays 2.
REQ-031 SHALL cover redirect with flush: redirect_pc=32'h0000_0021 -> PC=0x20, bubble (ifid_valid=0), then ifid_instr=32'h0000_1c63.
REQ-032 SHALL cover IF_STATIC_PREDICT_EN with backward branch: pc=0x34, rom_dout=32'hfc00_0ae3 -> next PC 0x08, ifid_pred_taken=1; macro off -> next PC 0x38, pred 0.
REQ-033 SHALL cover IF_STATIC_PREDICT_EN with self-loop JAL: pc=0x1C, rom_dout=32'h0000_0f6f -> PC stays 0x1C each cycle, ifid_pred_taken=1.
REQ-034 SHALL cover reset mid-operation: rst asserted with redirect_valid=1 -> PC=RESET_PC, ifid_valid=0.
